song_player: RTL and testbench

- Playback sequencer: the reader for the 16-entry note memory that the note-entry datapath writes.
- Steps the note address from 0 to a programmed last address, holding each note for a fixed tempo window followed by a silent gap.
- Drives the datapath's ld_play, note_counter and next_note_en inputs.
- Takes the looked-up half-period back on freq_in and generates the square-wave audio_out for the speaker/codec path.

---
 rtl/music_pkg.sv | 23 ++
 rtl/tone_gen.sv | 47 ++++
 rtl/song_player.sv | 138 +++++++++++++
 tb/tb_song_player.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/music_pkg.sv
// Shared types and widths for the song playback sequencer.
package music_pkg;

    localparam int NOTE_ADDR_W = 4;
    localparam int FREQ_W      = 32;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        FETCH   = 3'd1,
        PLAY    = 3'd2,
        GAP     = 3'd3,
        ADVANCE = 3'd4
    } state_t;

    // Largest of three cycle counts; sizes the shared phase counter.
    function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                         input int unsigned c);
        int unsigned m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/tone_gen.sv
// Square-wave generator: toggles audio_out every freq_q cycles while enabled.
// Output is forced low whenever disabled or freq_q is zero (a rest).
module tone_gen
    import music_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic [FREQ_W-1:0] freq_q,
    output logic              audio_out
);

    logic [FREQ_W-1:0] tone_cnt_q, tone_cnt_d;
    logic              tone_q, tone_d;
    logic              active;

    assign active = enable && (freq_q != '0);

    // Half-period counter and output phase; cleared whenever idle.
    always_comb begin
        tone_cnt_d = tone_cnt_q;
        tone_d     = tone_q;
        if (!active) begin
            tone_cnt_d = '0;
            tone_d     = 1'b0;
        end else if (tone_cnt_q == freq_q - FREQ_W'(1)) begin
            tone_cnt_d = '0;
            tone_d     = ~tone_q;
        end else begin
            tone_cnt_d = tone_cnt_q + FREQ_W'(1);
        end
    end

    // Synchronous active-low reset register stage.
    always_ff @(posedge clk) begin
        if (!reset) begin
            tone_cnt_q <= '0;
            tone_q     <= 1'b0;
        end else begin
            tone_cnt_q <= tone_cnt_d;
            tone_q     <= tone_d;
        end
    end

    assign audio_out = tone_q && active;

endmodule

// File: rtl/song_player.sv
// Playback sequencer for the 16-entry note memory: FETCH -> PLAY -> GAP -> ADVANCE
// per note, from address 0 up to the last address latched on start.
// Optional build macro SONG_PLAYER_LOOP_EN: after the last note, restart at
// address 0 instead of returning to IDLE (runs until stop).
module song_player
    import music_pkg::*;
#(
    parameter int unsigned NOTE_CYCLES  = 12500000,
    parameter int unsigned GAP_CYCLES   = 1250000,
    parameter int unsigned FETCH_CYCLES = 3
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic                   stop,
    input  logic [NOTE_ADDR_W-1:0] last_addr,
    input  logic [FREQ_W-1:0]      freq_in,
    output logic [NOTE_ADDR_W-1:0] note_counter,
    output logic                   ld_play,
    output logic                   next_note_en,
    output logic                   audio_out,
    output logic                   playing,
    output logic                   done
);

    localparam int unsigned MAX_C = max3(NOTE_CYCLES, GAP_CYCLES, FETCH_CYCLES);
    localparam int unsigned CNT_W = $clog2(MAX_C);

    localparam logic [CNT_W-1:0] FETCH_LAST = CNT_W'(FETCH_CYCLES - 1);
    localparam logic [CNT_W-1:0] NOTE_LAST  = CNT_W'(NOTE_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'((GAP_CYCLES == 0) ? 0 : GAP_CYCLES - 1);

    state_t                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [NOTE_ADDR_W-1:0] note_q, note_d;
    logic [NOTE_ADDR_W-1:0] last_q, last_d;
    logic [FREQ_W-1:0]      freq_q, freq_d;

    // Next-state logic; one phase counter is shared by FETCH, PLAY and GAP.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        note_d  = note_q;
        last_d  = last_q;
        freq_d  = freq_q;
        unique case (state_q)
            IDLE: begin
                if (start && !stop) begin
                    note_d  = '0;
                    last_d  = last_addr;
                    cnt_d   = '0;
                    state_d = FETCH;
                end
            end
            FETCH: begin
                if (cnt_q == FETCH_LAST) begin
                    freq_d  = freq_in;
                    cnt_d   = '0;
                    state_d = PLAY;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            PLAY: begin
                if (cnt_q == NOTE_LAST) begin
                    cnt_d   = '0;
                    state_d = (GAP_CYCLES == 0) ? ADVANCE : GAP;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            GAP: begin
                if (cnt_q == GAP_LAST) begin
                    cnt_d   = '0;
                    state_d = ADVANCE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ADVANCE: begin
                cnt_d = '0;
                if (note_q == last_q) begin
                    note_d = '0;
`ifdef SONG_PLAYER_LOOP_EN
                    state_d = FETCH;
`else
                    state_d = IDLE;
`endif
                end else begin
                    note_d  = note_q + NOTE_ADDR_W'(1);
                    state_d = FETCH;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
                note_d  = '0;
            end
        endcase
        if (stop && state_q != IDLE) begin
            state_d = IDLE;
            cnt_d   = '0;
            note_d  = '0;
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            note_q  <= '0;
            last_q  <= '0;
            freq_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            note_q  <= note_d;
            last_q  <= last_d;
            freq_q  <= freq_d;
        end
    end

    assign playing      = (state_q != IDLE);
    assign ld_play      = playing;
    assign next_note_en = (state_q == ADVANCE);
    assign done         = (state_q == ADVANCE) && (note_q == last_q);
    assign note_counter = note_q;

    tone_gen u_tone (
        .clk       (clk),
        .reset     (reset),
        .enable    (state_q == PLAY),
        .freq_q    (freq_q),
        .audio_out (audio_out)
    );

endmodule

// File: tb/tb_song_player.sv
// Directed bench for song_player with a 2-cycle address->freq datapath model.
module tb_song_player;

    localparam int NOTE  = 20;
    localparam int GAPC  = 4;
    localparam int FETCH = 3;
    localparam int SLOT  = FETCH + NOTE + GAPC + 1;

    logic        clk = 1'b0;
    logic        reset, start, stop;
    logic [3:0]  last_addr;
    logic [31:0] freq_in;
    logic [3:0]  note_counter;
    logic        ld_play, next_note_en, audio_out, playing, done;

    int total = 0;
    int bad   = 0;

    logic [31:0] mem [16];
    logic [3:0]  addr_d1;
    logic [3:0]  exp_q [$];

    song_player #(.NOTE_CYCLES(NOTE), .GAP_CYCLES(GAPC), .FETCH_CYCLES(FETCH)) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .stop         (stop),
        .last_addr    (last_addr),
        .freq_in      (freq_in),
        .note_counter (note_counter),
        .ld_play      (ld_play),
        .next_note_en (next_note_en),
        .audio_out    (audio_out),
        .playing      (playing),
        .done         (done)
    );

    always #5 clk = ~clk;

    // Datapath model: address register then memory/lookup register.
    always @(posedge clk) begin
        addr_d1 <= note_counter;
        freq_in <= mem[addr_d1];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_playing"}, 32'(playing), 0);
        chk({tag, "_ld_play"}, 32'(ld_play), 0);
        chk({tag, "_audio"}, 32'(audio_out), 0);
        chk({tag, "_note"}, 32'(note_counter), 0);
        chk({tag, "_nne"}, 32'(next_note_en), 0);
        chk({tag, "_done"}, 32'(done), 0);
    endtask

    // Runs a sequence cycle by cycle against a slot-timing model.
    // abort_at >= 0 stops (or resets, if abort_rst) at that cycle offset.
    // Leaves reset low after a reset abort; the caller releases it.
    task automatic play(input int last, input int nnotes, input int abort_at,
                        input bit abort_rst, input int start_at);
        int total_cyc;
        total_cyc = nnotes * SLOT;
        for (int i = 0; i < nnotes; i++) exp_q.push_back(4'(i % (last + 1)));
        last_addr = 4'(last);
        start = 1'b1;
        tick;
        start = 1'b0;
        for (int cyc = 0; cyc < total_cyc; cyc++) begin
            int  i, ph, a, k, f;
            logic e_aud;
            i  = cyc / SLOT;
            ph = cyc % SLOT;
            a  = i % (last + 1);
            k  = ph - FETCH;
            f  = int'(mem[a]);
            e_aud = (ph >= FETCH && ph < FETCH + NOTE && f != 0) ? ((k / f) % 2 == 1) : 1'b0;
            chk("note_counter", 32'(note_counter), 32'(a));
            chk("ld_play", 32'(ld_play), 1);
            chk("playing", 32'(playing), 1);
            chk("audio_out", 32'(audio_out), 32'(e_aud));
            chk("next_note_en", 32'(next_note_en), 32'(ph == SLOT - 1));
            chk("done", 32'(done), 32'(ph == SLOT - 1 && a == last));
            if (next_note_en && exp_q.size() > 0)
                chk("adv_addr", 32'(note_counter), 32'(exp_q.pop_front()));
            if (cyc == start_at) begin
                start     = 1'b1;
                last_addr = 4'(last + 3);
            end
            if (cyc == abort_at) begin
                if (abort_rst) reset = 1'b0;
                else           stop  = 1'b1;
                tick;
                stop = 1'b0;
                chk_idle(abort_rst ? "after_reset" : "after_stop");
                chk("queue_left", 32'(exp_q.size()), 32'(nnotes - i - int'(ph == SLOT - 1)));
                exp_q.delete();
                return;
            end
            tick;
            start = 1'b0;
        end
`ifdef SONG_PLAYER_LOOP_EN
        stop = 1'b1;
        tick;
        stop = 1'b0;
`endif
        chk("queue_left", 32'(exp_q.size()), 0);
        chk_idle("end");
    endtask

    initial begin
        reset = 1'b0; start = 1'b0; stop = 1'b0; last_addr = '0;
        for (int i = 0; i < 16; i++) mem[i] = '0;
        tick; tick; tick;
        chk_idle("reset");
        reset = 1'b1;
        tick;

        // Three notes: 5, rest, 1; done on the 84th cycle from FETCH entry.
        mem[0] = 32'd5; mem[1] = 32'd0; mem[2] = 32'd1;
        play(2, 3, -1, 1'b0, -1);
        tick;

        // Single note.
        mem[0] = 32'd3;
        play(0, 1, -1, 1'b0, -1);
        tick;

        // All 16 addresses, wrapping back to 0.
        for (int i = 0; i < 16; i++) mem[i] = 32'(i % 3);
        play(15, 16, -1, 1'b0, -1);
        tick;

        // Stop in the GAP of note 1, then start+stop together.
        mem[0] = 32'd2; mem[1] = 32'd4; mem[2] = 32'd1;
        play(2, 3, SLOT + FETCH + NOTE + 1, 1'b0, -1);
        start = 1'b1; stop = 1'b1;
        tick;
        start = 1'b0; stop = 1'b0;
        chk("start_stop_idle", 32'(playing), 0);
        tick;
        chk("start_stop_idle2", 32'(playing), 0);

        // Start (with a different last_addr) during PLAY is ignored.
        play(2, 3, -1, 1'b0, 10);
        tick;

        // Reset mid-PLAY of note 2; start under reset must not begin.
        play(2, 3, 2 * SLOT + FETCH + 5, 1'b1, -1);
        start = 1'b1;
        tick;
        chk("start_in_reset", 32'(playing), 0);
        chk("start_in_reset_ld", 32'(ld_play), 0);
        reset = 1'b1;
        start = 1'b0;
        tick;
        chk("start_released", 32'(playing), 0);

`ifdef SONG_PLAYER_LOOP_EN
        // Loop over addresses 0,1,0,1,0 then stop.
        mem[0] = 32'd2; mem[1] = 32'd3;
        play(1, 5, -1, 1'b0, -1);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
